// File: rtl/pack_pkg.sv
// Shared types and sizing helpers for the packet-generator input arbiter.
package pack_pkg;

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      PAD
   } pack_arb_state_t;

   localparam logic [7:0] PAD_BYTE_DFLT = 8'h00;

   // Preamble bytes are generated downstream, so only the payload is arbitrated.
   function automatic int payload_bytes(input int size_bit_pack,
                                        input int size_input_bit,
                                        input int sise_preamble);
      return size_bit_pack / size_input_bit - sise_preamble / size_input_bit;
   endfunction

endpackage

// File: rtl/pack_arbiter_rr_picker.sv
// Round-robin pick: first requester at or after i_ptr, wrapping; one-hot and index out.
// Purely combinational, no backpressure.
module rr_picker #(
   parameter int NUM_SRC = 4,
   localparam int IDX_W = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_SRC-1:0] o_win,
   output logic [IDX_W-1:0]   o_win_idx
);

   logic             w_found;
   logic [IDX_W-1:0] w_idx;

   always_comb begin
      w_found   = 1'b0;
      w_idx     = '0;
      o_win     = '0;
      o_win_idx = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_idx = IDX_W'((int'(i_ptr) + k) % NUM_SRC);
         if (!w_found && i_req[w_idx]) begin
            w_found      = 1'b1;
            o_win[w_idx] = 1'b1;
            o_win_idx    = w_idx;
         end
      end
   end

endmodule

// File: rtl/pack_arbiter.sv
// Grants one full payload per round-robin winner, padding early frame ends; grant one cycle
// after request, zero-latency data path, i_ready stalls XFER/PAD in place.
module pack_arbiter
   import pack_pkg::*;
#(
   parameter int NUM_SRC        = 4,
   parameter int SIZE_BIT_PACK  = 1976,
   parameter int SIZE_INPUT_BIT = 8,
   parameter int SISE_PREAMBLE  = 32,
   parameter int PAYLOAD_BYTES  = payload_bytes(SIZE_BIT_PACK, SIZE_INPUT_BIT, SISE_PREAMBLE),
   parameter logic [SIZE_INPUT_BIT-1:0] PAD_BYTE = SIZE_INPUT_BIT'(PAD_BYTE_DFLT)
) (
   input  logic                               i_clk,
   input  logic                               i_reset_n,
   input  logic [NUM_SRC-1:0]                 i_src_req,
   input  logic [NUM_SRC*SIZE_INPUT_BIT-1:0]  i_src_data,
   input  logic [NUM_SRC-1:0]                 i_src_valid,
   input  logic [NUM_SRC-1:0]                 i_src_last,
   output logic [NUM_SRC-1:0]                 o_src_ready,
   output logic [NUM_SRC-1:0]                 o_grant,
   output logic [SIZE_INPUT_BIT-1:0]          o_data,
   output logic                               o_valid,
   input  logic                               i_ready,
   output logic                               o_pkt_done,
   output logic                               o_padded
);

   localparam int IDX_W = $clog2(NUM_SRC);
   localparam int CNT_W = $clog2(PAYLOAD_BYTES);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PAYLOAD_BYTES - 1);

   pack_arb_state_t     r_state;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [IDX_W-1:0]    r_grant_idx;
   logic [NUM_SRC-1:0]  r_grant;
   logic [CNT_W-1:0]    r_beat_cnt;
   logic                r_pkt_done;
   logic                r_padded;

   logic [NUM_SRC-1:0]        w_win;
   logic [IDX_W-1:0]          w_win_idx;
   logic [SIZE_INPUT_BIT-1:0] w_src_byte [NUM_SRC];
   logic                      w_beat;
   logic                      w_final;
   logic                      w_src_last;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src_byte
      assign w_src_byte[g] = i_src_data[g*SIZE_INPUT_BIT +: SIZE_INPUT_BIT];
   end

   rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
      .i_req     (i_src_req),
      .i_ptr     (r_rr_ptr),
      .o_win     (w_win),
      .o_win_idx (w_win_idx)
   );

   always_comb begin
      o_data      = '0;
      o_valid     = 1'b0;
      o_src_ready = '0;
      case (r_state)
         XFER: begin
            o_data      = w_src_byte[r_grant_idx];
            o_valid     = i_src_valid[r_grant_idx];
            o_src_ready = r_grant & {NUM_SRC{i_ready}};
         end
         PAD: begin
            o_data  = PAD_BYTE;
            o_valid = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_beat     = o_valid & i_ready;
   assign w_final    = (r_beat_cnt == LAST_BEAT);
   assign w_src_last = i_src_last[r_grant_idx];

   assign o_grant    = r_grant;
   assign o_pkt_done = r_pkt_done;
   assign o_padded   = r_padded;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_grant_idx <= '0;
         r_grant     <= '0;
         r_beat_cnt  <= '0;
         r_pkt_done  <= 1'b0;
         r_padded    <= 1'b0;
      end else begin
         r_pkt_done <= 1'b0;
         r_padded   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (|i_src_req) begin
                  r_grant     <= w_win;
                  r_grant_idx <= w_win_idx;
                  r_beat_cnt  <= '0;
                  r_rr_ptr    <= (w_win_idx == IDX_W'(NUM_SRC - 1)) ? '0 : w_win_idx + 1'b1;
                  r_state     <= XFER;
               end
            end
            XFER: begin
               // A full payload wins over a coincident end-of-frame; surplus stays at the source.
               if (w_beat) begin
                  if (w_final) begin
                     r_state    <= IDLE;
                     r_grant    <= '0;
                     r_beat_cnt <= '0;
                     r_pkt_done <= 1'b1;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 1'b1;
                     if (w_src_last) r_state <= PAD;
                  end
               end
            end
            PAD: begin
               if (w_beat) begin
                  if (w_final) begin
                     r_state    <= IDLE;
                     r_grant    <= '0;
                     r_beat_cnt <= '0;
                     r_pkt_done <= 1'b1;
                     r_padded   <= 1'b1;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
